// File: rtl/address_sequencer_pkg.sv
// address_sequencer_pkg: shared types for the address sequencer
//   mode_t  : address generation mode carried in the two-bit mode field
//   state_t : sequencer FSM state
//   is_lfsr : true for either LFSR mode; the reserved code falls back to linear
package address_sequencer_pkg;
  typedef enum logic [1:0] {MODE_LINEAR, MODE_GALOIS, MODE_FIBONACCI, MODE_RESERVED} mode_t;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic is_lfsr(input mode_t m);
    return m == MODE_GALOIS || m == MODE_FIBONACCI;
  endfunction
endpackage

// File: rtl/address_sequencer_if.sv
// address_sequencer_if: command, configuration and address stream bundle
//   master : drives start/abort/config and address_ready; observes the stream
//   slave  : the sequencer; drives address_valid/address/busy/done
interface address_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int COUNT_WIDTH = 16
);
  logic start;
  logic abort;
  logic [1:0] mode;
  logic [WIDTH-1:0] range_start;
  logic [WIDTH-1:0] range_stop;
  logic [WIDTH-1:0] range_increment;
  logic [WIDTH-1:0] lfsr_seed;
  logic [WIDTH-1:0] lfsr_taps;
  logic [WIDTH-1:0] lfsr_mask;
  logic [WIDTH-1:0] final_mask;
  logic [COUNT_WIDTH-1:0] address_count;
  logic address_valid;
  logic address_ready;
  logic [WIDTH-1:0] address;
  logic busy;
  logic done;
  modport master (
    output start, abort, mode, range_start, range_stop, range_increment,
           lfsr_seed, lfsr_taps, lfsr_mask, final_mask, address_count, address_ready,
    input  address_valid, address, busy, done
  );
  modport slave (
    input  start, abort, mode, range_start, range_stop, range_increment,
           lfsr_seed, lfsr_taps, lfsr_mask, final_mask, address_count, address_ready,
    output address_valid, address, busy, done
  );
endinterface

// File: rtl/address_sequencer_lfsr_step.sv
// lfsr_step: one combinational Galois or Fibonacci LFSR step
//   current_i   : present state
//   taps_i      : tap mask
//   mask_i      : mask applied to the next state
//   fibonacci_i : 1 selects Fibonacci, 0 selects Galois
//   next_o      : masked next state
module lfsr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] current_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic             fibonacci_i,
  output logic [WIDTH-1:0] next_o
);
  logic [WIDTH-1:0] galois;
  logic [WIDTH-1:0] fibonacci;
  assign galois = (current_i >> 1) ^ (current_i[0] ? taps_i : '0);
  assign fibonacci = {^(current_i & taps_i), current_i[WIDTH-1:1]};
  assign next_o = (fibonacci_i ? fibonacci : galois) & mask_i;
endmodule

// File: rtl/address_sequencer.sv
// address_sequencer: handshaked bounded burst of linear or LFSR addresses
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : start/abort command, latched burst configuration,
//                  valid/ready address stream, busy level and done pulse
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic clock,
  input logic reset,
  address_sequencer_if.slave bus
);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] re_q, re_d;
  logic [WIDTH-1:0] inc_q, inc_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] lmask_q, lmask_d;
  logic [WIDTH-1:0] fmask_q, fmask_d;
  logic [COUNT_WIDTH-1:0] remain_q, remain_d;
  logic done_q, done_d;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] lin_next;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] seed_m;
  logic hs;
  lfsr_step #(.WIDTH(WIDTH)) u_lfsr (
    .current_i  (addr_q),
    .taps_i     (taps_q),
    .mask_i     (lmask_q),
    .fibonacci_i(mode_q == MODE_FIBONACCI),
    .next_o     (lfsr_next)
  );
  // The sum keeps its carry so an overflowing step always wraps to range_start.
  assign sum = {1'b0, addr_q} + {1'b0, inc_q};
  assign lin_next = sum > {1'b0, re_q} ? rs_q : sum[WIDTH-1:0];
  assign step_next = is_lfsr(mode_q) ? lfsr_next : lin_next;
  assign seed_m = bus.lfsr_seed & bus.lfsr_mask;
  assign hs = state_q == RUN && bus.address_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_LINEAR;
      addr_q   <= '0;
      rs_q     <= '0;
      re_q     <= '0;
      inc_q    <= '0;
      taps_q   <= '0;
      lmask_q  <= '0;
      fmask_q  <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      rs_q     <= rs_d;
      re_q     <= re_d;
      inc_q    <= inc_d;
      taps_q   <= taps_d;
      lmask_q  <= lmask_d;
      fmask_q  <= fmask_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    rs_d     = rs_q;
    re_d     = re_q;
    inc_d    = inc_q;
    taps_d   = taps_q;
    lmask_d  = lmask_q;
    fmask_d  = fmask_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        mode_d   = mode_t'(bus.mode);
        rs_d     = bus.range_start;
        re_d     = bus.range_stop;
        inc_d    = bus.range_increment;
        taps_d   = bus.lfsr_taps;
        lmask_d  = bus.lfsr_mask;
        fmask_d  = bus.final_mask;
        // An all-zero LFSR seed would lock up, so it is replaced by 1.
        addr_d   = is_lfsr(mode_t'(bus.mode)) ? (seed_m == '0 ? WIDTH'(1) : seed_m) : bus.range_start;
        remain_d = bus.address_count;
        state_d  = bus.address_count == '0 ? IDLE : RUN;
        done_d   = bus.address_count == '0;
      end
    end else begin
      addr_d   = hs ? step_next : addr_q;
      remain_d = hs ? remain_q - COUNT_WIDTH'(1) : remain_q;
      // A transfer taken together with abort still advances, but abort suppresses done.
      state_d  = (bus.abort || (hs && remain_q == COUNT_WIDTH'(1))) ? IDLE : RUN;
      done_d   = !bus.abort && hs && remain_q == COUNT_WIDTH'(1);
    end
  end
  always_comb begin
    bus.address_valid = state_q == RUN;
    bus.busy          = state_q == RUN;
    bus.done          = done_q;
    bus.address       = addr_q & fmask_q;
  end
endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: table-driven and directed checks of address_sequencer
module tb_address_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  address_sequencer_if #(.WIDTH(8), .COUNT_WIDTH(8)) bus ();
  address_sequencer #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );
  typedef struct {
    logic [1:0] mode;
    logic [7:0] rs, re, inc, seed, taps, lm, fm;
    int cnt;
    logic [0:7][7:0] exp;
  } vec_t;
  vec_t v [7];
  function automatic vec_t mk(input logic [1:0] m, input logic [7:0] rs, re, inc, seed, taps, lm, fm,
                              input int cnt, input logic [0:7][7:0] e);
    vec_t r;
    r.mode = m; r.rs = rs; r.re = re; r.inc = inc; r.seed = seed;
    r.taps = taps; r.lm = lm; r.fm = fm; r.cnt = cnt; r.exp = e;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [1:0] m, input logic [7:0] rs, re, inc, seed, taps, lm, fm, input int cnt);
    bus.mode = m; bus.range_start = rs; bus.range_stop = re; bus.range_increment = inc;
    bus.lfsr_seed = seed; bus.lfsr_taps = taps; bus.lfsr_mask = lm; bus.final_mask = fm;
    bus.address_count = 8'(cnt);
  endtask
  task automatic go;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask
  task automatic expect_addr(input string nm, input logic [7:0] a);
    chk({nm, " valid"}, bus.address_valid, 1);
    chk({nm, " addr"}, bus.address, a);
  endtask
  task automatic expect_done(input string nm);
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " busy_low"}, bus.busy, 0);
    chk({nm, " valid_low"}, bus.address_valid, 0);
    tick;
    chk({nm, " done_once"}, bus.done, 0);
  endtask
  task automatic expect_idle(input string nm);
    chk({nm, " valid"}, bus.address_valid, 0);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " done"}, bus.done, 0);
  endtask
  initial begin
    bus.start = 0; bus.abort = 0; bus.address_ready = 0;
    cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[0] = mk(2'd0, 8'h10, 8'h18, 8'h04, 8'h00, 8'h00, 8'hFF, 8'hFF, 5, {8'h10, 8'h14, 8'h18, 8'h10, 8'h14, 24'h0});
    v[1] = mk(2'd0, 8'hF0, 8'hFF, 8'h08, 8'h00, 8'h00, 8'hFF, 8'hFF, 3, {8'hF0, 8'hF8, 8'hF0, 40'h0});
    v[2] = mk(2'd1, 8'h00, 8'h00, 8'h00, 8'h01, 8'hB8, 8'hFF, 8'hFF, 6, {8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 16'h0});
    v[3] = mk(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'hFF, 8'hFF, 2, {8'h01, 8'hB8, 48'h0});
    v[4] = mk(2'd2, 8'h00, 8'h00, 8'h00, 8'h81, 8'hB8, 8'hFF, 8'hFF, 4, {8'h81, 8'hC0, 8'hE0, 8'h70, 32'h0});
    v[5] = mk(2'd3, 8'h21, 8'h30, 8'h07, 8'h00, 8'h00, 8'hFF, 8'h0F, 4, {8'h01, 8'h08, 8'h0F, 8'h01, 32'h0});
    v[6] = mk(2'd1, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hB8, 8'h7F, 8'hFF, 4, {8'h7F, 8'h07, 8'h3B, 8'h25, 32'h0});
    tick;
    tick;
    expect_idle("reset");
    chk("reset addr", bus.address, 0);
    rst = 0;
    tick;
    for (int k = 0; k < 7; k++) begin
      cfg(v[k].mode, v[k].rs, v[k].re, v[k].inc, v[k].seed, v[k].taps, v[k].lm, v[k].fm, v[k].cnt);
      bus.address_ready = 1;
      go;
      for (int i = 0; i < v[k].cnt; i++) begin
        expect_addr($sformatf("v%0d[%0d]", k, i), v[k].exp[i]);
        tick;
      end
      expect_done($sformatf("v%0d end", k));
    end
    cfg(0, 8'h00, 8'hFF, 8'h01, 0, 0, 8'hFF, 8'hFF, 4);
    bus.address_ready = 1;
    go;
    expect_addr("bp0", 8'h00);
    tick;
    bus.address_ready = 0;
    for (int i = 0; i < 3; i++) begin
      expect_addr($sformatf("bp stall%0d", i), 8'h01);
      tick;
    end
    bus.address_ready = 1;
    expect_addr("bp1", 8'h01);
    tick;
    expect_addr("bp2", 8'h02);
    tick;
    expect_addr("bp3", 8'h03);
    tick;
    expect_done("bp end");
    cfg(0, 8'h10, 8'h18, 8'h04, 0, 0, 8'hFF, 8'hFF, 0);
    go;
    expect_done("cnt0");
    chk("cnt0 valid_after", bus.address_valid, 0);
    cfg(0, 8'h10, 8'h18, 8'h04, 0, 0, 8'hFF, 8'hFF, 5);
    go;
    expect_addr("mid0", 8'h10);
    tick;
    cfg(0, 8'h50, 8'h60, 8'h01, 0, 0, 8'hFF, 8'hFF, 2);
    bus.start = 1;
    expect_addr("mid1", 8'h14);
    tick;
    bus.start = 0;
    expect_addr("mid2", 8'h18);
    tick;
    expect_addr("mid3", 8'h10);
    tick;
    expect_addr("mid4", 8'h14);
    tick;
    expect_done("mid end");
    cfg(0, 8'h10, 8'h18, 8'h04, 0, 0, 8'hFF, 8'hFF, 5);
    go;
    expect_addr("ab0", 8'h10);
    tick;
    expect_addr("ab1", 8'h14);
    tick;
    bus.address_ready = 0;
    bus.abort = 1;
    expect_addr("ab2", 8'h18);
    tick;
    bus.abort = 0;
    expect_idle("ab after");
    tick;
    chk("ab no_done", bus.done, 0);
    cfg(0, 8'h40, 8'h50, 8'h01, 0, 0, 8'hFF, 8'hFF, 1);
    go;
    expect_addr("ab restart", 8'h40);
    bus.address_ready = 1;
    tick;
    expect_done("ab restart end");
    cfg(0, 8'h33, 8'h50, 8'h01, 0, 0, 8'hFF, 8'hFF, 1);
    go;
    expect_addr("abhs", 8'h33);
    bus.abort = 1;
    tick;
    bus.abort = 0;
    expect_idle("abhs after");
    tick;
    chk("abhs no_done", bus.done, 0);
    cfg(0, 8'h10, 8'h18, 8'h04, 0, 0, 8'hFF, 8'hFF, 2);
    bus.abort = 1;
    go;
    bus.abort = 0;
    expect_addr("idle_abort0", 8'h10);
    tick;
    expect_addr("idle_abort1", 8'h14);
    tick;
    expect_done("idle_abort end");
    cfg(0, 8'h10, 8'h18, 8'h04, 0, 0, 8'hFF, 8'hFF, 5);
    go;
    tick;
    expect_addr("rst mid", 8'h14);
    rst = 1;
    tick;
    rst = 0;
    expect_idle("rst after");
    chk("rst addr", bus.address, 0);
    tick;
    expect_idle("rst later");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
